hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_raw_compare.sv | 39 +++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard unit.
//   fwd_sel_t  - operand source select codes driven on fwd_a / fwd_b
//   NOP_OP     - opcode placed in the top 5 bits of a squashed/bubbled slot
//   flush_st_t - wrong-path flush FSM states
//   FCNT_W     - width of the flush down-counter (FLUSH_DEPTH <= 7)
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_E   = 2'b01,
    FWD_M   = 2'b10,
    FWD_W   = 2'b11
  } fwd_sel_t;

  localparam logic [4:0] NOP_OP = 5'b00001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_st_t;

  localparam int unsigned FCNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signal bundle of the hazard unit.
//   master - pipeline: drives IF/ID instruction, decode source flags,
//            per-stage write info, load_e and redirect; reads the results
//   slave  - hazard_ctrl: instr_out, pc_stall, ifid_stall, fwd_a, fwd_b,
//            flushing, stall_cnt, flush_cnt
interface hazard_ctrl_if #(
  parameter int unsigned XLEN    = 16,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned CNT_W   = 16
);
  logic [XLEN-1:0]    instr_in;
  logic               src1_used;
  logic               src2_used;
  logic               wr_en_e;
  logic               wr_en_m;
  logic               wr_en_w;
  logic [RADDR_W-1:0] wr_reg_e;
  logic [RADDR_W-1:0] wr_reg_m;
  logic [RADDR_W-1:0] wr_reg_w;
  logic               load_e;
  logic               redirect;
  logic [XLEN-1:0]    instr_out;
  logic               pc_stall;
  logic               ifid_stall;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
  logic               flushing;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output instr_in, src1_used, src2_used,
    output wr_en_e, wr_en_m, wr_en_w, wr_reg_e, wr_reg_m, wr_reg_w,
    output load_e, redirect,
    input  instr_out, pc_stall, ifid_stall, fwd_a, fwd_b,
    input  flushing, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_in, src1_used, src2_used,
    input  wr_en_e, wr_en_m, wr_en_w, wr_reg_e, wr_reg_m, wr_reg_w,
    input  load_e, redirect,
    output instr_out, pc_stall, ifid_stall, fwd_a, fwd_b,
    output flushing, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_raw_compare.sv
// raw_compare: RAW detection for one source operand.
//   used           - decode marks the field as a real source
//   field          - source register address
//   wr_en_*/wr_reg_* - write enable and destination of EX, MEM, WB
//   hit            - {w, m, e} match vector
//   fwd_sel        - youngest matching stage, E > M > W, else FWD_REG
module raw_compare
  import hazard_pkg::*;
#(
  parameter int unsigned RADDR_W  = 3,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic               used,
  input  logic [RADDR_W-1:0] field,
  input  logic               wr_en_e,
  input  logic               wr_en_m,
  input  logic               wr_en_w,
  input  logic [RADDR_W-1:0] wr_reg_e,
  input  logic [RADDR_W-1:0] wr_reg_m,
  input  logic [RADDR_W-1:0] wr_reg_w,
  output logic [2:0]         hit,
  output fwd_sel_t           fwd_sel
);
  logic qual;

  // Register 0 is hardwired, so it never carries a dependency.
  assign qual = used & ~(ZERO_REG & (field == '0));

  assign hit[0] = qual & wr_en_e & (field == wr_reg_e);
  assign hit[1] = qual & wr_en_m & (field == wr_reg_m);
  assign hit[2] = qual & wr_en_w & (field == wr_reg_w);

  always_comb begin
    fwd_sel = FWD_REG;
    if (hit[0])      fwd_sel = FWD_E;
    else if (hit[1]) fwd_sel = FWD_M;
    else if (hit[2]) fwd_sel = FWD_W;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard resolution and wrong-path squash between IF/ID
// and decode.
//   clk, rst - clock; asynchronous active-high reset
//   bus      - hazard_ctrl_if slave: instruction, source/destination info,
//              load_e, redirect in; instr_out, pc_stall, ifid_stall,
//              fwd_a, fwd_b, flushing, stall_cnt, flush_cnt out
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN        = 16,
  parameter int unsigned RADDR_W     = 3,
  parameter int unsigned SRC1_LSB    = 8,
  parameter int unsigned SRC2_LSB    = 5,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter bit          FWD_EN      = 1'b1,
  parameter bit          ZERO_REG    = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
);
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_DEPTH - 1);
  localparam bit                MULTI     = (FLUSH_DEPTH > 1);

  logic [2:0]        hit1, hit2;
  fwd_sel_t          fwd1_raw, fwd2_raw;
  fwd_sel_t          fwd1, fwd2;
  logic              stall, squash;
  logic [XLEN-1:0]   nop;
  flush_st_t         state, state_n;
  logic [FCNT_W-1:0] cnt, cnt_n;
  logic              pc_stall_o;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  raw_compare #(.RADDR_W(RADDR_W), .ZERO_REG(ZERO_REG)) u_cmp1 (
    .used     (bus.src1_used),
    .field    (bus.instr_in[SRC1_LSB +: RADDR_W]),
    .wr_en_e  (bus.wr_en_e),
    .wr_en_m  (bus.wr_en_m),
    .wr_en_w  (bus.wr_en_w),
    .wr_reg_e (bus.wr_reg_e),
    .wr_reg_m (bus.wr_reg_m),
    .wr_reg_w (bus.wr_reg_w),
    .hit      (hit1),
    .fwd_sel  (fwd1_raw)
  );

  raw_compare #(.RADDR_W(RADDR_W), .ZERO_REG(ZERO_REG)) u_cmp2 (
    .used     (bus.src2_used),
    .field    (bus.instr_in[SRC2_LSB +: RADDR_W]),
    .wr_en_e  (bus.wr_en_e),
    .wr_en_m  (bus.wr_en_m),
    .wr_en_w  (bus.wr_en_w),
    .wr_reg_e (bus.wr_reg_e),
    .wr_reg_m (bus.wr_reg_m),
    .wr_reg_w (bus.wr_reg_w),
    .hit      (hit2),
    .fwd_sel  (fwd2_raw)
  );

  // Without forwarding every RAW must wait for writeback.
  assign fwd1  = FWD_EN ? fwd1_raw : FWD_REG;
  assign fwd2  = FWD_EN ? fwd2_raw : FWD_REG;
  assign stall = FWD_EN ? (bus.load_e & (hit1[0] | hit2[0])) : (|{hit1, hit2});

  assign squash = bus.redirect | (state == ST_FLUSH);
  assign nop    = {NOP_OP, bus.instr_in[XLEN-6:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt holds the FLUSH cycles still owed after the current one is counted;
  // leaving on cnt<=1 makes a redirect squash exactly FLUSH_DEPTH cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.redirect && MULTI) begin
          state_n = ST_FLUSH;
          cnt_n   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (bus.redirect) begin
          cnt_n = FLUSH_LOAD;
        end else if (cnt <= FCNT_W'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - FCNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    bus.instr_out  = bus.instr_in;
    pc_stall_o     = 1'b0;
    bus.ifid_stall = 1'b0;
    bus.fwd_a      = fwd1;
    bus.fwd_b      = fwd2;
    if (rst || squash) begin
      bus.instr_out = nop;
      bus.fwd_a     = FWD_REG;
      bus.fwd_b     = FWD_REG;
    end else if (stall) begin
      bus.instr_out  = nop;
      pc_stall_o     = 1'b1;
      bus.ifid_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.redirect && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_stall  = pc_stall_o;
  assign bus.flushing  = (state == ST_FLUSH);
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test of three hazard_ctrl builds sharing one
// stimulus: u0 default (FLUSH_DEPTH=2, FWD_EN=1), u1 FWD_EN=0,
// u2 FLUSH_DEPTH=3.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] instr_in;
  logic        src1_used, src2_used;
  logic        wr_en_e, wr_en_m, wr_en_w;
  logic [2:0]  wr_reg_e, wr_reg_m, wr_reg_w;
  logic        load_e, redirect;

  int checks = 0;
  int passed = 0;
  logic [15:0] exp_nop;

  hazard_ctrl_if #(.XLEN(16), .RADDR_W(3), .CNT_W(16)) bus0 ();
  hazard_ctrl_if #(.XLEN(16), .RADDR_W(3), .CNT_W(16)) bus1 ();
  hazard_ctrl_if #(.XLEN(16), .RADDR_W(3), .CNT_W(16)) bus2 ();

  assign bus0.instr_in = instr_in;   assign bus1.instr_in = instr_in;   assign bus2.instr_in = instr_in;
  assign bus0.src1_used = src1_used; assign bus1.src1_used = src1_used; assign bus2.src1_used = src1_used;
  assign bus0.src2_used = src2_used; assign bus1.src2_used = src2_used; assign bus2.src2_used = src2_used;
  assign bus0.wr_en_e = wr_en_e;     assign bus1.wr_en_e = wr_en_e;     assign bus2.wr_en_e = wr_en_e;
  assign bus0.wr_en_m = wr_en_m;     assign bus1.wr_en_m = wr_en_m;     assign bus2.wr_en_m = wr_en_m;
  assign bus0.wr_en_w = wr_en_w;     assign bus1.wr_en_w = wr_en_w;     assign bus2.wr_en_w = wr_en_w;
  assign bus0.wr_reg_e = wr_reg_e;   assign bus1.wr_reg_e = wr_reg_e;   assign bus2.wr_reg_e = wr_reg_e;
  assign bus0.wr_reg_m = wr_reg_m;   assign bus1.wr_reg_m = wr_reg_m;   assign bus2.wr_reg_m = wr_reg_m;
  assign bus0.wr_reg_w = wr_reg_w;   assign bus1.wr_reg_w = wr_reg_w;   assign bus2.wr_reg_w = wr_reg_w;
  assign bus0.load_e = load_e;       assign bus1.load_e = load_e;       assign bus2.load_e = load_e;
  assign bus0.redirect = redirect;   assign bus1.redirect = redirect;   assign bus2.redirect = redirect;

  hazard_ctrl #(.FLUSH_DEPTH(2), .FWD_EN(1'b1)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  hazard_ctrl #(.FLUSH_DEPTH(2), .FWD_EN(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  hazard_ctrl #(.FLUSH_DEPTH(3), .FWD_EN(1'b1)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // opcode 10100 | src1 [10:8] | src2 [7:5] | low 00011
  function automatic logic [15:0] mk(input logic [2:0] s1, input logic [2:0] s2);
    return {5'b10100, s1, s2, 5'b00011};
  endfunction

  task automatic idle_inputs();
    instr_in = mk(3'd6, 3'd7);
    src1_used = 1'b0; src2_used = 1'b0;
    wr_en_e = 1'b0; wr_en_m = 1'b0; wr_en_w = 1'b0;
    wr_reg_e = 3'd0; wr_reg_m = 3'd0; wr_reg_w = 3'd0;
    load_e = 1'b0; redirect = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    instr_in = mk(3'd2, 3'd1); src1_used = 1'b1;
    wr_en_e = 1'b1; wr_reg_e = 3'd2; load_e = 1'b1;
    exp_nop = {5'b00001, 11'b01000100011};
    #2;
    checks++; if (bus0.instr_out !== exp_nop) $display("FAIL rst_instr got=%h exp=%h", bus0.instr_out, exp_nop); else passed++;
    checks++; if (bus0.pc_stall !== 1'b0 || bus1.pc_stall !== 1'b0) $display("FAIL rst_stall got=%b/%b exp=0", bus0.pc_stall, bus1.pc_stall); else passed++;
    checks++; if (bus0.fwd_a !== 2'b00) $display("FAIL rst_fwd_a got=%b exp=00", bus0.fwd_a); else passed++;
    checks++; if (bus2.flushing !== 1'b0) $display("FAIL rst_flushing got=%b exp=0", bus2.flushing); else passed++;
    checks++; if (bus0.stall_cnt !== 16'd0 || bus2.flush_cnt !== 16'd0) $display("FAIL rst_cnt got=%0d/%0d exp=0", bus0.stall_cnt, bus2.flush_cnt); else passed++;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_fwd_ex();
    idle_inputs();
    instr_in = mk(3'd3, 3'd1); src1_used = 1'b1;
    wr_en_e = 1'b1; wr_reg_e = 3'd3;
    #1;
    checks++; if (bus0.fwd_a !== 2'b01) $display("FAIL fwd_e_a got=%b exp=01", bus0.fwd_a); else passed++;
    checks++; if (bus0.pc_stall !== 1'b0) $display("FAIL fwd_e_stall got=%b exp=0", bus0.pc_stall); else passed++;
    checks++; if (bus0.instr_out !== 16'hA323) $display("FAIL fwd_e_instr got=%h exp=a323", bus0.instr_out); else passed++;
    checks++; if (bus0.fwd_b !== 2'b00) $display("FAIL fwd_e_b got=%b exp=00", bus0.fwd_b); else passed++;
    next_cycle();
  endtask

  task automatic test_priority();
    idle_inputs();
    instr_in = mk(3'd1, 3'd5); src2_used = 1'b1;
    wr_en_m = 1'b1; wr_reg_m = 3'd5; wr_en_w = 1'b1; wr_reg_w = 3'd5;
    #1;
    checks++; if (bus0.fwd_b !== 2'b10) $display("FAIL prio_b got=%b exp=10", bus0.fwd_b); else passed++;
    wr_en_m = 1'b0;
    #1;
    checks++; if (bus0.fwd_b !== 2'b11) $display("FAIL prio_w got=%b exp=11", bus0.fwd_b); else passed++;
    next_cycle();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    instr_in = mk(3'd0, 3'd4); src1_used = 1'b1;
    wr_en_e = 1'b1; wr_reg_e = 3'd0; load_e = 1'b1;
    #1;
    checks++; if (bus0.pc_stall !== 1'b0) $display("FAIL zero_stall got=%b exp=0", bus0.pc_stall); else passed++;
    checks++; if (bus0.fwd_a !== 2'b00) $display("FAIL zero_fwd got=%b exp=00", bus0.fwd_a); else passed++;
    next_cycle();
  endtask

  task automatic test_load_use();
    idle_inputs();
    instr_in = mk(3'd2, 3'd1); src1_used = 1'b1;
    wr_en_e = 1'b1; wr_reg_e = 3'd2; load_e = 1'b1;
    #1;
    checks++; if (bus0.pc_stall !== 1'b1 || bus0.ifid_stall !== 1'b1) $display("FAIL lu_stall got=%b/%b exp=1/1", bus0.pc_stall, bus0.ifid_stall); else passed++;
    checks++; if (bus0.instr_out !== 16'h0A23) $display("FAIL lu_nop got=%h exp=0a23", bus0.instr_out); else passed++;
    next_cycle();
    // load now in MEM, bubble in EX
    wr_en_e = 1'b0; load_e = 1'b0; wr_en_m = 1'b1; wr_reg_m = 3'd2;
    #1;
    checks++; if (bus0.fwd_a !== 2'b10) $display("FAIL lu_fwd_m got=%b exp=10", bus0.fwd_a); else passed++;
    checks++; if (bus0.pc_stall !== 1'b0) $display("FAIL lu_one_cycle got=%b exp=0", bus0.pc_stall); else passed++;
    checks++; if (bus0.stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", bus0.stall_cnt); else passed++;
    next_cycle();
  endtask

  task automatic test_no_fwd();
    idle_inputs();
    instr_in = mk(3'd4, 3'd1); src1_used = 1'b1;
    wr_en_w = 1'b1; wr_reg_w = 3'd4;
    #1;
    checks++; if (bus1.pc_stall !== 1'b1) $display("FAIL nofwd_stall got=%b exp=1", bus1.pc_stall); else passed++;
    checks++; if (bus1.fwd_a !== 2'b00) $display("FAIL nofwd_fwd got=%b exp=00", bus1.fwd_a); else passed++;
    checks++; if (bus0.fwd_a !== 2'b11 || bus0.pc_stall !== 1'b0) $display("FAIL fwd_w got=%b/%b exp=11/0", bus0.fwd_a, bus0.pc_stall); else passed++;
    next_cycle();
  endtask

  task automatic test_back_to_back_redirect();
    idle_inputs();
    // c0: redirect with a load-use hazard present
    instr_in = mk(3'd2, 3'd1); src1_used = 1'b1;
    wr_en_e = 1'b1; wr_reg_e = 3'd2; load_e = 1'b1; redirect = 1'b1;
    #1;
    checks++; if (bus2.instr_out !== 16'h0A23) $display("FAIL rd_c0_nop got=%h exp=0a23", bus2.instr_out); else passed++;
    checks++; if (bus2.pc_stall !== 1'b0 || bus0.pc_stall !== 1'b0) $display("FAIL rd_beats_stall got=%b/%b exp=0", bus2.pc_stall, bus0.pc_stall); else passed++;
    checks++; if (bus2.flushing !== 1'b0) $display("FAIL rd_c0_flushing got=%b exp=0", bus2.flushing); else passed++;
    next_cycle();
    // c1: second redirect
    idle_inputs(); instr_in = mk(3'd3, 3'd3); redirect = 1'b1;
    #1;
    checks++; if (bus2.flushing !== 1'b1) $display("FAIL rd_c1_flushing got=%b exp=1", bus2.flushing); else passed++;
    next_cycle();
    redirect = 1'b0;
    #1;
    checks++; if (bus2.flushing !== 1'b1 || bus2.instr_out !== 16'h0B63) $display("FAIL rd_c2 got=%b/%h exp=1/0b63", bus2.flushing, bus2.instr_out); else passed++;
    next_cycle();
    #1;
    checks++; if (bus2.flushing !== 1'b1 || bus2.instr_out !== 16'h0B63) $display("FAIL rd_c3 got=%b/%h exp=1/0b63", bus2.flushing, bus2.instr_out); else passed++;
    checks++; if (bus0.flushing !== 1'b0 || bus0.instr_out !== 16'hA363) $display("FAIL rd_d2_c3 got=%b/%h exp=0/a363", bus0.flushing, bus0.instr_out); else passed++;
    next_cycle();
    #1;
    checks++; if (bus2.flushing !== 1'b0 || bus2.instr_out !== 16'hA363) $display("FAIL rd_c4 got=%b/%h exp=0/a363", bus2.flushing, bus2.instr_out); else passed++;
    checks++; if (bus2.flush_cnt !== 16'd2 || bus0.flush_cnt !== 16'd2) $display("FAIL rd_flush_cnt got=%0d/%0d exp=2", bus2.flush_cnt, bus0.flush_cnt); else passed++;
    checks++; if (bus0.stall_cnt !== 16'd1) $display("FAIL rd_stall_cnt got=%0d exp=1", bus0.stall_cnt); else passed++;
    next_cycle();
  endtask

  task automatic test_reset_mid_flush();
    idle_inputs(); redirect = 1'b1;
    next_cycle();
    redirect = 1'b0;
    #1;
    checks++; if (bus2.flushing !== 1'b1) $display("FAIL mf_pre got=%b exp=1", bus2.flushing); else passed++;
    instr_in = mk(3'd2, 3'd1); src1_used = 1'b1;
    wr_en_e = 1'b1; wr_reg_e = 3'd2; load_e = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (bus2.flushing !== 1'b0) $display("FAIL mf_flushing got=%b exp=0", bus2.flushing); else passed++;
    checks++; if (bus2.flush_cnt !== 16'd0 || bus0.stall_cnt !== 16'd0) $display("FAIL mf_cnt got=%0d/%0d exp=0", bus2.flush_cnt, bus0.stall_cnt); else passed++;
    checks++; if (bus0.pc_stall !== 1'b0 || bus0.instr_out !== 16'h0A23) $display("FAIL mf_out got=%b/%h exp=0/0a23", bus0.pc_stall, bus0.instr_out); else passed++;
    idle_inputs();
    #1;
    rst = 1'b0;
    next_cycle();
    #1;
    checks++; if (bus2.flushing !== 1'b0 || bus2.instr_out !== 16'hA6E3) $display("FAIL mf_after got=%b/%h exp=0/a6e3", bus2.flushing, bus2.instr_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_priority();
    test_zero_reg();
    test_load_use();
    test_no_fwd();
    test_back_to_back_redirect();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
